// File: rtl/button_cmd_encoder.sv
// Synchronises and debounces five push-buttons, adds per-button delayed auto-repeat and
// merges press/repeat events into one lowest-index-first command stream with valid/ready.

module button_cmd_encoder #(
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned DAS_CYC      = 20000000,
  parameter int unsigned ARR_CYC      = 5000000,
  parameter logic [4:0]  REPEAT_MASK  = 5'b01110,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BUTTON_C,
  input  logic       BUTTON_E,
  input  logic       BUTTON_W,
  input  logic       BUTTON_S,
  input  logic       BUTTON_N,
  input  logic       I_CMD_READY,
  output logic       O_CMD_VALID,
  output logic [2:0] O_CMD_CODE,
  output logic       O_DROP
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYC - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HELD
  } btn_state_t;

  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] evt;
  logic [4:0] pending;

  // Bit order matches the command code: 0=C .. 4=N.
  assign raw = {BUTTON_N, BUTTON_S, BUTTON_W, BUTTON_E, BUTTON_C};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_btn
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             deb;
    logic             evt_q;
    logic             settle;
    logic             rise;
    logic             fall;
    btn_state_t       state;

    // The FSM reacts on the same edge the debounced level flips, so the
    // registered event lines up with the new debounced level.
    assign settle = (sync2[i] != deb) && (deb_cnt == DEB_LAST);
    assign rise   = settle && sync2[i];
    assign fall   = settle && !sync2[i];
    assign evt[i] = evt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_cnt <= '0;
        deb     <= 1'b0;
      end else if (sync2[i] == deb) begin
        deb_cnt <= '0;
      end else if (settle) begin
        deb     <= sync2[i];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        rep_cnt <= '0;
        evt_q   <= 1'b0;
      end else begin
        evt_q <= 1'b0;
        if (fall) begin
          state   <= IDLE;
          rep_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise) begin
                evt_q   <= 1'b1;
                rep_cnt <= '0;
                state   <= REPEAT_MASK[i] ? DELAY : HELD;
              end
            end
            DELAY: begin
              if (rep_cnt == DAS_LAST) begin
                evt_q   <= 1'b1;
                rep_cnt <= '0;
                state   <= REPEAT;
              end else begin
                rep_cnt <= rep_cnt + CNT_ONE;
              end
            end
            REPEAT: begin
              if (rep_cnt == ARR_LAST) begin
                evt_q   <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + CNT_ONE;
              end
            end
            HELD: begin
              rep_cnt <= '0;
            end
            default: begin
              state   <= IDLE;
              rep_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  logic       load;
  logic       have;
  logic [2:0] pick;
  logic [4:0] consume;
  logic [4:0] pending_next;
  logic       drop_any;

  always_comb begin
    pick = '0;
    for (int j = 4; j >= 0; j--) begin
      if (pending[j]) pick = 3'(j);
    end
    have    = |pending;
    load    = !O_CMD_VALID || I_CMD_READY;
    consume = (load && have) ? (5'b00001 << pick) : 5'b00000;
    // A new event on a bit that is leaving this edge simply re-arms it.
    drop_any     = |(evt & pending & ~consume);
    pending_next = (pending & ~consume) | evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      O_DROP      <= 1'b0;
      O_CMD_VALID <= 1'b0;
      O_CMD_CODE  <= '0;
    end else begin
      pending <= pending_next;
      O_DROP  <= drop_any;
      if (load) begin
        O_CMD_VALID <= have;
        if (have) O_CMD_CODE <= pick;
      end
    end
  end

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Randomised and directed bench for button_cmd_encoder against an event-timing reference model.
module tb_button_cmd_encoder;

  localparam int DEB = 4;
  localparam int DAS = 20;
  localparam int ARR = 5;
  localparam logic [4:0] RMASK = 5'b01110;

  logic       clk;
  logic       rst;
  logic [4:0] btn;
  logic       rdy;
  logic       vld;
  logic [2:0] code;
  logic       drop;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  button_cmd_encoder #(
    .DEBOUNCE_CYC(DEB), .DAS_CYC(DAS), .ARR_CYC(ARR), .REPEAT_MASK(RMASK), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .BUTTON_C(btn[0]), .BUTTON_E(btn[1]), .BUTTON_W(btn[2]),
    .BUTTON_S(btn[3]), .BUTTON_N(btn[4]),
    .I_CMD_READY(rdy), .O_CMD_VALID(vld), .O_CMD_CODE(code), .O_DROP(drop)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: debounce as "last DEB synchronised samples all differ",
  // events as arithmetic on time since press, then pending/priority/output stage.
  bit [4:0] raw_q[$];
  bit [4:0] sync_q[$];
  bit [4:0] m_deb, m_evt, m_pend, m_new, m_cons;
  bit [4:0] m_sync;
  bit       m_vld, m_drop, m_flip;
  bit [2:0] m_code;
  int       m_edge, m_pick, m_n;
  int       m_press[5];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q.delete();
      sync_q.delete();
      m_deb = '0; m_evt = '0; m_pend = '0;
      m_vld = 0; m_drop = 0; m_code = '0; m_edge = 0;
    end else begin
      m_edge++;
      m_sync = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 5'b0;
      raw_q.push_back(btn);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      sync_q.push_back(m_sync);
      if (sync_q.size() > DEB) void'(sync_q.pop_front());

      m_pick = -1;
      for (int j = 0; j < 5; j++) if (m_pend[j] && m_pick < 0) m_pick = j;
      m_cons = '0;
      if (!m_vld || rdy) begin
        if (m_pick >= 0) begin
          m_vld = 1;
          m_code = 3'(m_pick);
          m_cons[m_pick] = 1'b1;
        end else begin
          m_vld = 0;
        end
      end
      m_drop = |(m_evt & m_pend & ~m_cons);
      m_pend = (m_pend & ~m_cons) | m_evt;

      m_new = '0;
      for (int i = 0; i < 5; i++) begin
        m_flip = (sync_q.size() == DEB);
        for (int k = 0; k < DEB; k++)
          if (m_flip && sync_q[k][i] == m_deb[i]) m_flip = 0;
        if (m_flip) begin
          m_deb[i] = !m_deb[i];
          if (m_deb[i]) begin
            m_press[i] = m_edge;
            m_new[i] = 1'b1;
          end
        end else if (m_deb[i] && RMASK[i]) begin
          m_n = m_edge - m_press[i];
          if (m_n >= DAS && ((m_n - DAS) % ARR) == 0) m_new[i] = 1'b1;
        end
      end
      m_evt = m_new;
    end
  end

  int acc_t[$];
  int acc_c[$];
  int drop_t[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("out{vld,code,drop}", {28'd0, vld, code, drop}, {28'd0, m_vld, m_code, m_drop});
      if (vld && rdy) begin
        acc_t.push_back(cyc);
        acc_c.push_back(int'(code));
      end
      if (drop) drop_t.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_t.delete();
    acc_c.delete();
    drop_t.delete();
  endtask

  int k;
  int rel[9] = '{0, 20, 25, 30, 35, 40, 45, 50, 55};
  int b;

  initial begin
    rst = 1; btn = '0; rdy = 1;
    step(3);
    rst = 0;
    step(2);
    chk_en = 1;
    check("reset_vld", {31'd0, vld}, 32'd0);
    check("reset_code", {29'd0, code}, 32'd0);
    check("reset_drop", {31'd0, drop}, 32'd0);

    // single press on a non-repeating button
    clear_logs(); k = cyc; btn[0] = 1;
    step(100); btn[0] = 0; step(20);
    check("c_count", acc_t.size(), 1);
    if (acc_t.size() > 0) begin
      check("c_time", acc_t[0], k + 8);
      check("c_code", acc_c[0], 0);
    end
    check("c_drops", drop_t.size(), 0);

    // glitch shorter than the debounce window
    clear_logs(); btn[1] = 1; step(3); btn[1] = 0; step(20);
    check("e_glitch_count", acc_t.size(), 0);

    // auto-repeat on S
    clear_logs(); k = cyc; btn[3] = 1;
    step(60); btn[3] = 0; step(40);
    check("s_count", acc_t.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < acc_t.size()) begin
        check("s_time", acc_t[i], k + 8 + rel[i]);
        check("s_code", acc_c[i], 3);
      end
    end

    // backpressure: one pending, one dropped
    clear_logs(); rdy = 0; k = cyc; btn[3] = 1;
    step(30); btn[3] = 0; step(20);
    check("bp_accepts_stalled", acc_t.size(), 0);
    check("bp_drop_count", drop_t.size(), 1);
    if (drop_t.size() > 0) check("bp_drop_time", drop_t[0], k + 32);
    check("bp_vld_held", {31'd0, vld}, 32'd1);
    check("bp_code_held", {29'd0, code}, 32'd3);
    rdy = 1; step(5);
    check("bp_release_count", acc_t.size(), 2);
    if (acc_t.size() == 2) begin
      check("bp_first", acc_t[0], k + 50);
      check("bp_second", acc_t[1], k + 51);
      check("bp_second_code", acc_c[1], 3);
    end

    // simultaneous C and N
    clear_logs(); k = cyc; btn[0] = 1; btn[4] = 1;
    step(20); btn[0] = 0; btn[4] = 0; step(20);
    check("cn_count", acc_t.size(), 2);
    if (acc_t.size() == 2) begin
      check("cn_code0", acc_c[0], 0);
      check("cn_code1", acc_c[1], 4);
      check("cn_t1", acc_t[1], acc_t[0] + 1);
    end
    check("cn_drops", drop_t.size(), 0);

    // reset in the middle of W auto-repeat
    clear_logs(); k = cyc; btn[2] = 1;
    step(33);
    check("w_pre_rst_vld", {31'd0, vld}, 32'd1);
    #2 rst = 1;
    #1;
    check("w_rst_vld", {31'd0, vld}, 32'd0);
    check("w_rst_code", {29'd0, code}, 32'd0);
    step(2);
    rst = 0; clear_logs(); k = cyc;
    step(40); btn[2] = 0; step(20);
    check("w_after_count", acc_t.size(), 5);
    if (acc_t.size() >= 2) begin
      check("w_after_t0", acc_t[0], k + 8);
      check("w_after_code", acc_c[0], 2);
      check("w_after_t1", acc_t[1], k + 28);
    end

    // random buttons and backpressure against the model
    for (int it = 0; it < 300; it++) begin
      b = $urandom_range(0, 4);
      btn[b] = !btn[b];
      rdy = ($urandom_range(0, 3) != 0);
      step($urandom_range(1, 25));
    end
    btn = '0; rdy = 1;
    step(120);
    check("final_idle_vld", {31'd0, vld}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
